mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux; holds the grant until the owner releases.
// Optional forced release after MAX_HOLD grant cycles when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       sel_valid,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned REQ_W = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Elaboration-time range check on the forced-release limit
    if ((MAX_HOLD < 1) || (64'(MAX_HOLD) >= (64'(1) << HOLD_WIDTH))) begin : g_max_hold_check
        $error("mux4_rr_arbiter: MAX_HOLD must be >= 1 and < 2**HOLD_WIDTH");
    end

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
    logic [REQ_W-1:0]        grant_q, grant_d;
    logic [SEL_W-1:0]        select_q, select_d;
    logic                    sel_valid_q, sel_valid_d;
    logic                    busy_q, busy_d;
    logic                    timeout_q, timeout_d;

    logic [SEL_W-1:0]        winner;
    logic                    owner_release;
    logic                    force_release;
    logic [HOLD_WIDTH-1:0]   hold_inc;

    // First set request scanning ptr+1 .. ptr+4; the previous winner ranks last
    function automatic logic [SEL_W-1:0] rr_pick(input logic [REQ_W-1:0] r,
                                                 input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        pick = p;
        for (int k = REQ_W; k >= 1; k--) begin
            idx = p + SEL_W'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign winner        = rr_pick(req, ptr_q);
    assign owner_release = done[ptr_q] | ~req[ptr_q];
    assign hold_inc      = (hold_q == {HOLD_WIDTH{1'b1}}) ? hold_q : hold_q + HOLD_WIDTH'(1);

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);
    assign force_release = (hold_q == HOLD_LAST);
`else
    assign force_release = 1'b0;
`endif

    // State and registered-output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= SEL_W'(REQ_W - 1);
            hold_q      <= '0;
            grant_q     <= '0;
            select_q    <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            grant_q     <= grant_d;
            select_q    <= select_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        grant_d     = grant_q;
        select_d    = select_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d     = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
                if (|req) begin
                    state_d     = ST_GRANT;
                    ptr_d       = winner;
                    hold_d      = '0;
                    grant_d     = REQ_W'(1) << winner;
                    select_d    = winner;
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_GRANT: begin
                busy_d = 1'b1;
                hold_d = hold_inc;
                if (owner_release) begin
                    state_d     = ST_GAP;
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                end else if (force_release) begin
                    // Owner keeps its ptr slot, so it ranks last next time
                    state_d     = ST_GAP;
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end
            end

            ST_GAP: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d     = ST_IDLE;
                grant_d     = '0;
                sel_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign select    = select_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: per-cycle expected outputs are queued as stimulus is driven.
// Expected word layout: {grant[3:0], select[1:0], sel_valid, busy, timeout}.
module tb_mux4_rr_arbiter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] req  = 4'b0000;
    logic [3:0] done = 4'b0000;
    logic [3:0] grant;
    logic [1:0] select;
    logic       sel_valid;
    logic       busy;
    logic       timeout;
    logic [8:0] obs;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q [$];

    mux4_rr_arbiter #(
        .HOLD_WIDTH (8),
        .MAX_HOLD   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .select    (select),
        .sel_valid (sel_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    assign obs = {grant, select, sel_valid, busy, timeout};

    task automatic apply_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        done = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        @(posedge clk);
        #1;
        exp_q.push_back(9'b0000_00_0_0_0);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_idle: got=%b want=%b", obs, e);
        end
        req = 4'b1111;
        exp_q.push_back(9'b0000_00_0_0_0);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_with_req: got=%b want=%b", obs, e);
        end
        req = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_single_owner();
        logic [16:0] tbl [$];
        logic [8:0]  e;
        apply_reset();
        tbl = '{
            {4'b0001, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0001, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0001, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0001, 4'b0001, 9'b0000_00_0_1_0},
            {4'b0000, 4'b0000, 9'b0000_00_0_0_0},
            {4'b0000, 4'b0000, 9'b0000_00_0_0_0}
        };
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL single_owner step %0d: got=%b want=%b", i, obs, e);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [16:0] tbl [$];
        logic [8:0]  e;
        apply_reset();
        tbl = '{
            {4'b1111, 4'b0000, 9'b0001_00_1_1_0},
            {4'b1111, 4'b0000, 9'b0001_00_1_1_0},
            {4'b1111, 4'b0001, 9'b0000_00_0_1_0},
            {4'b1111, 4'b0000, 9'b0000_00_0_0_0},
            {4'b1111, 4'b0000, 9'b0010_01_1_1_0},
            {4'b1111, 4'b0000, 9'b0010_01_1_1_0},
            {4'b1111, 4'b0010, 9'b0000_01_0_1_0},
            {4'b1111, 4'b0000, 9'b0000_01_0_0_0},
            {4'b1111, 4'b0000, 9'b0100_10_1_1_0},
            {4'b1111, 4'b0000, 9'b0100_10_1_1_0},
            {4'b1111, 4'b0100, 9'b0000_10_0_1_0},
            {4'b1111, 4'b0000, 9'b0000_10_0_0_0},
            {4'b1111, 4'b0000, 9'b1000_11_1_1_0},
            {4'b1111, 4'b0000, 9'b1000_11_1_1_0},
            {4'b1111, 4'b1000, 9'b0000_11_0_1_0},
            {4'b1111, 4'b0000, 9'b0000_11_0_0_0},
            {4'b1111, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0000, 4'b0000, 9'b0000_00_0_1_0},
            {4'b0000, 4'b0000, 9'b0000_00_0_0_0}
        };
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL round_robin step %0d: got=%b want=%b", i, obs, e);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    task automatic test_non_owner_done();
        logic [16:0] tbl [$];
        logic [8:0]  e;
        apply_reset();
        tbl = '{
            {4'b0100, 4'b0000, 9'b0100_10_1_1_0},
            {4'b0100, 4'b1011, 9'b0100_10_1_1_0},
            {4'b0100, 4'b1011, 9'b0100_10_1_1_0},
            {4'b0100, 4'b0000, 9'b0100_10_1_1_0},
            {4'b0100, 4'b0100, 9'b0000_10_0_1_0},
            {4'b0000, 4'b0100, 9'b0000_10_0_0_0},
            {4'b0000, 4'b0100, 9'b0000_10_0_0_0}
        };
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL non_owner_done step %0d: got=%b want=%b", i, obs, e);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        logic [16:0] tbl [$];
        logic [8:0]  e;
        apply_reset();
        tbl = '{
            {4'b0010, 4'b0000, 9'b0010_01_1_1_0},
            {4'b0010, 4'b0000, 9'b0010_01_1_1_0}
        };
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid_grant pre step %0d: got=%b want=%b", i, obs, e);
            end
        end
        // Assert reset between clock edges; outputs must clear without a clock
        #3;
        rst = 1'b1;
        exp_q.push_back(9'b0000_00_0_0_0);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_mid_grant async: got=%b want=%b", obs, e);
        end
        req = 4'b0110;
        @(posedge clk);
        #1;
        rst = 1'b0;
        // ptr back at 3: of requesters 1 and 2, requester 1 must win
        tbl = '{
            {4'b0110, 4'b0000, 9'b0010_01_1_1_0},
            {4'b0000, 4'b0000, 9'b0000_01_0_1_0},
            {4'b0000, 4'b0000, 9'b0000_01_0_0_0}
        };
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid_grant post step %0d: got=%b want=%b", i, obs, e);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    task automatic test_req_drop();
        logic [16:0] tbl [$];
        logic [8:0]  e;
        apply_reset();
        tbl = '{
            {4'b1000, 4'b0000, 9'b1000_11_1_1_0},
            {4'b1001, 4'b0000, 9'b1000_11_1_1_0},
            {4'b0001, 4'b0000, 9'b0000_11_0_1_0},
            {4'b0001, 4'b0000, 9'b0000_11_0_0_0},
            {4'b0001, 4'b0000, 9'b0001_00_1_1_0},
            {4'b1001, 4'b0001, 9'b0000_00_0_1_0},
            {4'b1001, 4'b0000, 9'b0000_00_0_0_0},
            {4'b1001, 4'b0000, 9'b1000_11_1_1_0},
            {4'b0000, 4'b1000, 9'b0000_11_0_1_0},
            {4'b0000, 4'b0000, 9'b0000_11_0_0_0}
        };
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL req_drop step %0d: got=%b want=%b", i, obs, e);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    task automatic test_hold_timeout();
        logic [16:0] tbl [$];
        logic [8:0]  e;
        apply_reset();
`ifdef MUX4_ARB_TIMEOUT_EN
        tbl = '{
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0000_00_0_1_1},
            {4'b0011, 4'b0000, 9'b0000_00_0_0_0},
            {4'b0011, 4'b0000, 9'b0010_01_1_1_0},
            {4'b0011, 4'b0000, 9'b0010_01_1_1_0},
            {4'b0011, 4'b0000, 9'b0010_01_1_1_0},
            {4'b0011, 4'b0000, 9'b0010_01_1_1_0},
            {4'b0011, 4'b0010, 9'b0000_01_0_1_0},
            {4'b0000, 4'b0000, 9'b0000_01_0_0_0}
        };
`else
        tbl = '{
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0011, 4'b0000, 9'b0001_00_1_1_0},
            {4'b0000, 4'b0000, 9'b0000_00_0_1_0},
            {4'b0000, 4'b0000, 9'b0000_00_0_0_0}
        };
`endif
        foreach (tbl[i]) begin
            req  = tbl[i][16:13];
            done = tbl[i][12:9];
            exp_q.push_back(tbl[i][8:0]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL hold_timeout step %0d: got=%b want=%b", i, obs, e);
            end
        end
        req  = 4'b0000;
        done = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_round_robin();
        test_non_owner_done();
        test_reset_mid_grant();
        test_req_drop();
        test_hold_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
